// File: rtl/core_mem_bridge.sv
// core_mem_bridge: routes the core's single outstanding load/store to data SRAM, the GEMM
// register window or an unmapped region. Optional accelerator watchdog: `define BUS_TIMEOUT_EN.
module core_mem_bridge #(
    parameter int          RAM_AW         = 12,
    parameter logic [31:0] ACC_BASE       = 32'h8000_0000,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              mem_rd_wr,
    input  logic [3:0]        mask,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_write_data,
    output logic [31:0]       mem_read_data,
    output logic              mem_valid,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              acc_req,
    output logic              acc_we,
    output logic [7:0]        acc_addr,
    output logic [31:0]       acc_wdata,
    output logic [3:0]        acc_mask,
    input  logic              acc_ready,
    input  logic              acc_rvalid,
    input  logic [31:0]       acc_rdata,
    output logic              bus_err
);

    localparam logic [31:0] RAM_BYTES = 32'd4 << RAM_AW;
    localparam logic [31:0] TMO_DATA  = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {IDLE, RAM, ACC_REQ, ACC_WAIT, RESP} state_t;

    state_t             r_state;
    logic [RAM_AW-1:0]  r_ram_addr;
    logic [7:0]         r_acc_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_mask;
    logic               r_rd;
    logic [31:0]        r_rdata;
    logic               r_ram_rd;
    logic               r_ram_en;
    logic [3:0]         r_ram_we;
    logic               r_acc_req;
    logic               r_acc_we;
    logic               r_bus_err;

    logic w_ram_hit;
    logic w_acc_hit;
    logic w_tmo;

    assign w_ram_hit = (mem_addr < RAM_BYTES);
    assign w_acc_hit = (mem_addr[31:8] == ACC_BASE[31:8]);

`ifdef BUS_TIMEOUT_EN
    localparam int               TMO_W    = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] r_tmo_cnt;

    // Held at zero in IDLE, so it starts from zero on every entry to ACC_REQ.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_tmo_cnt <= '0;
        else if (r_state == ACC_REQ || r_state == ACC_WAIT)
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        else
            r_tmo_cnt <= '0;
    end

    assign w_tmo = (r_tmo_cnt == TMO_LAST);
`else
    assign w_tmo = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_ram_addr <= '0;
            r_acc_addr <= '0;
            r_wdata    <= '0;
            r_mask     <= '0;
            r_rd       <= 1'b0;
            r_rdata    <= '0;
            r_ram_rd   <= 1'b0;
            r_ram_en   <= 1'b0;
            r_ram_we   <= '0;
            r_acc_req  <= 1'b0;
            r_acc_we   <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_ram_en  <= 1'b0;
            r_ram_we  <= '0;
            r_ram_rd  <= 1'b0;
            r_bus_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cs) begin
                        r_ram_addr <= mem_addr[RAM_AW+1:2];
                        r_acc_addr <= mem_addr[7:0];
                        r_wdata    <= mem_write_data;
                        r_mask     <= mask;
                        r_rd       <= mem_rd_wr;
                        if (w_ram_hit) begin
                            r_state  <= RAM;
                            r_ram_en <= 1'b1;
                            r_ram_we <= mem_rd_wr ? 4'b0000 : mask;
                        end else if (w_acc_hit) begin
                            r_state   <= ACC_REQ;
                            r_acc_req <= 1'b1;
                            r_acc_we  <= ~mem_rd_wr;
                        end else begin
                            // Unmapped: writes are dropped, reads return zero.
                            r_state   <= RESP;
                            r_bus_err <= 1'b1;
                            if (mem_rd_wr)
                                r_rdata <= '0;
                        end
                    end
                end
                RAM: begin
                    r_ram_rd <= r_rd;
                    r_state  <= RESP;
                end
                ACC_REQ: begin
                    if (acc_ready) begin
                        r_acc_req <= 1'b0;
                        r_acc_we  <= 1'b0;
                        if (!r_rd) begin
                            r_state <= RESP;
                        end else if (acc_rvalid) begin
                            r_rdata <= acc_rdata;
                            r_state <= RESP;
                        end else begin
                            r_state <= ACC_WAIT;
                        end
                    end else if (w_tmo) begin
                        r_acc_req <= 1'b0;
                        r_acc_we  <= 1'b0;
                        r_rdata   <= TMO_DATA;
                        r_bus_err <= 1'b1;
                        r_state   <= RESP;
                    end
                end
                ACC_WAIT: begin
                    if (acc_rvalid) begin
                        r_rdata <= acc_rdata;
                        r_state <= RESP;
                    end else if (w_tmo) begin
                        r_rdata   <= TMO_DATA;
                        r_bus_err <= 1'b1;
                        r_state   <= RESP;
                    end
                end
                RESP: begin
                    if (r_ram_rd)
                        r_rdata <= ram_rdata;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // SRAM data arrives during RESP itself, so it bypasses r_rdata for that one cycle.
    assign mem_read_data = r_ram_rd ? ram_rdata : r_rdata;
    assign mem_valid     = (r_state == RESP) || (r_state == IDLE && !cs);

    assign ram_en    = r_ram_en;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_wdata;
    assign acc_req   = r_acc_req;
    assign acc_we    = r_acc_we;
    assign acc_addr  = r_acc_addr;
    assign acc_wdata = r_wdata;
    assign acc_mask  = r_mask;
    assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_core_mem_bridge.sv
// Scoreboard bench for core_mem_bridge: the driver predicts each response from an abstract
// memory/accelerator model; a negedge monitor pops and compares on every completion.
module tb_core_mem_bridge;

    localparam int RAM_AW = 12;
    localparam int TMO    = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              cs = 1'b0;
    logic              mem_rd_wr = 1'b0;
    logic [3:0]        mask = '0;
    logic [31:0]       mem_addr = '0;
    logic [31:0]       mem_write_data = '0;
    logic [31:0]       mem_read_data;
    logic              mem_valid;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic              acc_req;
    logic              acc_we;
    logic [7:0]        acc_addr;
    logic [31:0]       acc_wdata;
    logic [3:0]        acc_mask;
    logic              acc_ready = 1'b0;
    logic              acc_rvalid = 1'b0;
    logic [31:0]       acc_rdata = '0;
    logic              bus_err;

    core_mem_bridge #(.RAM_AW(RAM_AW), .ACC_BASE(32'h8000_0000), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .cs(cs), .mem_rd_wr(mem_rd_wr), .mask(mask),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
        .mem_valid(mem_valid), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .acc_req(acc_req), .acc_we(acc_we),
        .acc_addr(acc_addr), .acc_wdata(acc_wdata), .acc_mask(acc_mask), .acc_ready(acc_ready),
        .acc_rvalid(acc_rvalid), .acc_rdata(acc_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // SRAM device: one-cycle read latency, byte-lane writes.
    logic [31:0] sram [1<<RAM_AW];
    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) sram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            ram_rdata <= sram[ram_addr];
        end
    end

    // Accelerator device: ready after acc_cfg_d stall cycles, read data acc_cfg_r cycles later.
    int          acc_cfg_d = 0;
    int          acc_cfg_r = 0;
    bit          acc_cfg_rd = 1'b0;
    logic [31:0] acc_cfg_data = '0;

    initial begin
        int a_cnt;
        int a_wait;
        bit a_phase;
        a_cnt = 0;
        a_wait = 0;
        a_phase = 1'b0;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                acc_ready = 1'b0;
                acc_rvalid = 1'b0;
                a_cnt = 0;
                a_phase = 1'b0;
            end else begin
                #1;
                acc_ready = 1'b0;
                acc_rvalid = 1'b0;
                if (a_phase) begin
                    a_wait--;
                    if (a_wait == 0) begin
                        acc_rvalid = 1'b1;
                        acc_rdata = acc_cfg_data;
                        a_phase = 1'b0;
                    end
                end else if (acc_req) begin
                    if (a_cnt == acc_cfg_d) begin
                        acc_ready = 1'b1;
                        a_cnt = 0;
                        if (acc_cfg_rd) begin
                            if (acc_cfg_r == 0) begin
                                acc_rvalid = 1'b1;
                                acc_rdata = acc_cfg_data;
                            end else begin
                                a_phase = 1'b1;
                                a_wait = acc_cfg_r;
                            end
                        end
                    end else begin
                        a_cnt++;
                    end
                end else begin
                    a_cnt = 0;
                end
            end
        end
    end

    typedef struct {
        bit                chk_data;
        logic [31:0]       data;
        bit                err;
        int                lat;
        int                n_ram;
        logic [RAM_AW-1:0] ram_addr;
        logic [3:0]        ram_we;
        logic [31:0]       ram_wdata;
        int                n_acc;
        logic [7:0]        acc_addr;
        bit                acc_we;
        logic [31:0]       acc_wdata;
        logic [3:0]        acc_mask;
    } exp_t;

    exp_t sb[$];
    int   t_start = 0;

    // Monitor: accumulates side-effects per request and compares when the core sees completion.
    initial begin
        int                n_ram, n_acc, n_err;
        logic [RAM_AW-1:0] c_ram_addr;
        logic [3:0]        c_ram_we;
        logic [31:0]       c_ram_wdata, c_acc_wdata;
        logic [7:0]        c_acc_addr;
        logic              c_acc_we;
        logic [3:0]        c_acc_mask;
        bit                c_unstable;
        exp_t              e;
        n_ram = 0; n_acc = 0; n_err = 0; c_unstable = 1'b0;
        c_ram_addr = '0; c_ram_we = '0; c_ram_wdata = '0;
        c_acc_addr = '0; c_acc_we = 1'b0; c_acc_wdata = '0; c_acc_mask = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                n_ram = 0; n_acc = 0; n_err = 0; c_unstable = 1'b0;
            end else begin
                if (ram_en) begin
                    n_ram++;
                    c_ram_addr = ram_addr;
                    c_ram_we = ram_we;
                    c_ram_wdata = ram_wdata;
                end
                if (acc_req) begin
                    if (n_acc == 0) begin
                        c_acc_addr = acc_addr;
                        c_acc_we = acc_we;
                        c_acc_wdata = acc_wdata;
                        c_acc_mask = acc_mask;
                    end else if ({acc_addr, acc_we, acc_wdata, acc_mask} !==
                                 {c_acc_addr, c_acc_we, c_acc_wdata, c_acc_mask}) begin
                        c_unstable = 1'b1;
                    end
                    n_acc++;
                end
                if (bus_err) n_err++;
                if (cs && mem_valid) begin
                    check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("latency", cyc - t_start, e.lat);
                        if (e.chk_data) check("rdata", mem_read_data, e.data);
                        check("bus_err", 32'(bus_err), 32'(e.err));
                        check("bus_err_cycles", n_err, 32'(e.err));
                        check("ram_en_cycles", n_ram, e.n_ram);
                        if (e.n_ram != 0) begin
                            check("ram_addr", 32'(c_ram_addr), 32'(e.ram_addr));
                            check("ram_we", 32'(c_ram_we), 32'(e.ram_we));
                            if (e.ram_we != 0) check("ram_wdata", c_ram_wdata, e.ram_wdata);
                        end
                        check("acc_req_cycles", n_acc, e.n_acc);
                        if (e.n_acc != 0) begin
                            check("acc_addr", 32'(c_acc_addr), 32'(e.acc_addr));
                            check("acc_we", 32'(c_acc_we), 32'(e.acc_we));
                            if (e.acc_we) begin
                                check("acc_wdata", c_acc_wdata, e.acc_wdata);
                                check("acc_mask", 32'(c_acc_mask), 32'(e.acc_mask));
                            end
                            check("acc_stable", 32'(c_unstable), 32'd0);
                        end
                    end
                    n_ram = 0; n_acc = 0; n_err = 0; c_unstable = 1'b0;
                end
            end
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [1<<RAM_AW];
    logic [31:0] last_rd = '0;

    task automatic txn(input bit rd, input logic [3:0] m, input logic [31:0] a,
                       input logic [31:0] wd, input int d, input int r, input logic [31:0] ad);
        exp_t e;
        bit   done;
        int   w;
        done = 1'b0;
        if (!rd) r = 0;
        e = '{default: 0};
        e.chk_data = 1'b1;
        if (a < (32'd4 << RAM_AW)) begin
            w = int'(a >> 2);
            e.lat = 2;
            e.n_ram = 1;
            e.ram_addr = w[RAM_AW-1:0];
            e.ram_we = rd ? 4'b0000 : m;
            e.ram_wdata = wd;
            if (rd) begin
                e.data = ref_mem[w];
                last_rd = e.data;
            end else begin
                for (int b = 0; b < 4; b++)
                    if (m[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
                e.data = last_rd;
            end
        end else if (a[31:8] == 24'h80_0000) begin
            e.n_acc = d + 1;
            e.acc_addr = a[7:0];
            e.acc_we = !rd;
            e.acc_wdata = wd;
            e.acc_mask = m;
            e.lat = d + 2 + r;
            if (rd) begin
                e.data = ad;
                last_rd = ad;
            end else begin
                e.data = last_rd;
            end
`ifdef BUS_TIMEOUT_EN
            if (d + 1 + r > TMO) begin
                e.n_acc = (d + 1 < TMO) ? d + 1 : TMO;
                e.lat = TMO + 1;
                e.err = 1'b1;
                e.data = 32'hDEAD_BEEF;
                last_rd = 32'hDEAD_BEEF;
            end
`endif
        end else begin
            e.lat = 1;
            e.err = 1'b1;
            if (rd) begin
                e.data = '0;
                last_rd = '0;
            end else begin
                e.chk_data = 1'b0;
            end
        end
        sb.push_back(e);
        acc_cfg_d = d;
        acc_cfg_r = r;
        acc_cfg_rd = rd;
        acc_cfg_data = ad;
        @(posedge clk);
        #1;
        cs = 1'b1;
        mem_rd_wr = rd;
        mask = m;
        mem_addr = a;
        mem_write_data = wd;
        t_start = cyc;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mem_valid) begin
                done = 1'b1;
                break;
            end
        end
        check("completion_watchdog", 32'(done), 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cs = 1'b0;
            mem_addr = $urandom;
            mem_rd_wr = 1'($urandom);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          idx, kind, d, r;
        bit          rd;
        logic [3:0]  m;
        logic [31:0] a;

        for (int i = 0; i < (1 << RAM_AW); i++) ref_mem[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_valid", 32'(mem_valid), 32'd1);
        check("rst_ram_en", 32'(ram_en), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_acc_req", 32'(acc_req), 32'd0);
        check("rst_acc_we", 32'(acc_we), 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_rdata", mem_read_data, 32'd0);
        reset = 1'b1;
        idle(2);

        // Preload the address pool: low words and the top of the SRAM.
        for (int i = 0; i < 16; i++)
            txn(1'b0, 4'hF, ((i < 8) ? i : 4080 + i) * 4, $urandom, 0, 0, 0);
        idle(1);

        txn(1'b0, 4'hF, 32'h0000_0010, 32'hA5A5_1234, 0, 0, 0);
        txn(1'b1, 4'hF, 32'h0000_0010, 32'h0, 0, 0, 0);
        txn(1'b0, 4'b0100, 32'h0000_0012, 32'h00EE_0000, 0, 0, 0);
        txn(1'b1, 4'hF, 32'h0000_0010, 32'h0, 0, 0, 0);
        idle(1);
        txn(1'b1, 4'hF, 32'h8000_0008, 32'h0, 3, 2, 32'h0000_00C3);
        idle(1);
        txn(1'b0, 4'hF, 32'h4000_0000, 32'h1111_2222, 0, 0, 0);
        txn(1'b1, 4'hF, 32'h0000_4000, 32'h0, 0, 0, 0);
        txn(1'b1, 4'hF, 32'h8000_0100, 32'h0, 0, 0, 0);
        txn(1'b0, 4'b0011, 32'h8000_00FC, 32'hCAFE_F00D, 1, 0, 0);
        txn(1'b1, 4'hF, 32'h0000_3FFC, 32'h0, 0, 0, 0);
        txn(1'b1, 4'hF, 32'h8000_0004, 32'h0, 0, 0, 32'h1234_5678);
        idle(1);

        // Back-to-back: SRAM read directly followed by an accelerator write.
        txn(1'b1, 4'hF, 32'h0000_0004, 32'h0, 0, 0, 0);
        txn(1'b0, 4'hF, 32'h8000_0040, 32'h5555_AAAA, 2, 0, 0);

        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 9);
            rd = 1'($urandom);
            m = 4'($urandom);
            d = $urandom_range(0, 4);
            r = $urandom_range(0, 3);
            if (kind < 5) begin
                idx = $urandom_range(0, 15);
                a = ((idx < 8) ? idx : 4080 + idx) * 4 + $urandom_range(0, 3);
            end else if (kind < 8) begin
                a = 32'h8000_0000 | $urandom_range(0, 255);
            end else begin
                a = 32'h4000_0000 | ($urandom & 32'h3FFF_FFFF);
            end
            txn(rd, m, a, $urandom, d, r, $urandom);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end
        idle(2);

        // Reset while the bridge waits for accelerator read data.
        acc_cfg_d = 1;
        acc_cfg_r = 20;
        acc_cfg_rd = 1'b1;
        acc_cfg_data = 32'h9999_9999;
        @(posedge clk);
        #1;
        cs = 1'b1;
        mem_rd_wr = 1'b1;
        mem_addr = 32'h8000_0010;
        repeat (4) @(posedge clk);
        #1;
        check("wait_acc_req_low", 32'(acc_req), 32'd0);
        check("wait_stalled", 32'(mem_valid), 32'd0);
        reset = 1'b0;
        cs = 1'b0;
        #1;
        check("midrst_acc_req", 32'(acc_req), 32'd0);
        check("midrst_mem_valid", 32'(mem_valid), 32'd1);
        check("midrst_bus_err", 32'(bus_err), 32'd0);
        check("midrst_rdata", mem_read_data, 32'd0);
        last_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        idle(2);
        txn(1'b1, 4'hF, 32'h0000_0010, 32'h0, 0, 0, 0);
        txn(1'b0, 4'hF, 32'h8000_0020, 32'h0BAD_CAFE, 0, 0, 0);
        idle(1);

`ifdef BUS_TIMEOUT_EN
        txn(1'b1, 4'hF, 32'h8000_0030, 32'h0, 1000, 0, 32'h0);
        idle(1);
        txn(1'b1, 4'hF, 32'h8000_0034, 32'h0, 2, 80, 32'h7777_7777);
        idle(1);
`endif

        idle(3);
        check("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
